// File: rtl/mem_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter.
package mem_pkg;

  // Memory side is word addressed: byte address [31:2].
  localparam int WADDR_W = 30;

  // MMIO write targets intercepted when MMIO_DECODE_EN is defined.
  localparam logic [31:0] MEM_PUTC = 32'h8000_001c;
  localparam logic [31:0] MEM_EXIT = 32'h8000_002c;

  // Which requester owns the read currently returning from memory.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/execute ports, the arbiter and the memory.
// slave  : arbiter side (takes requests, drives grants and memory strobes)
// master : requester/memory side (drives requests and memory read data)
interface mem_arbiter_if;
  import mem_pkg::*;

  // instruction fetch port
  logic                 if_req;
  logic [31:0]          if_addr;
  logic                 if_gnt;
  logic                 if_rvalid;
  logic [31:0]          if_rdata;

  // data read port
  logic                 d_rreq;
  logic [31:0]          d_raddr;
  logic                 d_gnt;
  logic                 d_rvalid;
  logic [31:0]          d_rdata;

  // data write port
  logic                 d_wreq;
  logic [31:0]          d_waddr;
  logic [31:0]          d_wdata;
  logic [3:0]           d_wstrb;

  // memory read port
  logic                 mem_rready;
  logic [WADDR_W-1:0]   mem_raddr;
  logic [31:0]          mem_rdata;

  // memory write port
  logic                 mem_wready;
  logic [WADDR_W-1:0]   mem_waddr;
  logic [31:0]          mem_wdata;
  logic [3:0]           mem_wstrb;

  // MMIO side effects
  logic                 putc_valid;
  logic [7:0]           putc_char;
  logic                 exit_req;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_rreq, d_raddr,
    output d_gnt, d_rvalid, d_rdata,
    input  d_wreq, d_waddr, d_wdata, d_wstrb,
    output mem_rready, mem_raddr,
    input  mem_rdata,
    output mem_wready, mem_waddr, mem_wdata, mem_wstrb,
    output putc_valid, putc_char, exit_req
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_rreq, d_raddr,
    input  d_gnt, d_rvalid, d_rdata,
    output d_wreq, d_waddr, d_wdata, d_wstrb,
    input  mem_rready, mem_raddr,
    output mem_rdata,
    input  mem_wready, mem_waddr, mem_wdata, mem_wstrb,
    input  putc_valid, putc_char, exit_req
  );

endinterface

// File: rtl/mem_arbiter.sv
// Unified memory arbiter: one read port shared by instruction fetch and data
// reads (data priority, fetch starvation guard, RAW deferral), data writes
// passed straight to the write port, one outstanding read routed back to its
// owner.
//
// Optional feature macro: MMIO_DECODE_EN -- intercepts writes to the PUTC and
// EXIT addresses instead of sending them to memory.
//
// State (owner register):
//   state    | meaning
//   OWN_NONE | no read returning this cycle
//   OWN_IF   | mem_rdata this cycle belongs to fetch
//   OWN_D    | mem_rdata this cycle belongs to the data port
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4   // legal 1..15
) (
  input  logic          clk,
  input  logic          resetb,
  mem_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  owner_e              owner_q, owner_d;
  logic [3:0]          lose_cnt_q, lose_cnt_d;

  logic [WADDR_W-1:0]  if_word, d_word, w_word;
  logic                mmio_putc, mmio_exit;
  logic                mem_w;
  logic                raw_if, raw_d;
  logic                if_ok, d_ok;
  logic                fetch_pri;
  logic                grant_if, grant_d;

  assign if_word = bus.if_addr[31:2];
  assign d_word  = bus.d_raddr[31:2];
  assign w_word  = bus.d_waddr[31:2];

`ifdef MMIO_DECODE_EN
  assign mmio_putc = bus.d_wreq && (bus.d_waddr == MEM_PUTC);
  assign mmio_exit = bus.d_wreq && (bus.d_waddr == MEM_EXIT);
`else
  assign mmio_putc = 1'b0;
  assign mmio_exit = 1'b0;
`endif

  // MMIO writes never reach memory, so they can never cause a RAW conflict.
  assign mem_w  = bus.d_wreq && !(mmio_putc || mmio_exit);
  assign raw_if = mem_w && (w_word == if_word);
  assign raw_d  = mem_w && (w_word == d_word);
  assign if_ok  = bus.if_req && !raw_if;
  assign d_ok   = bus.d_rreq && !raw_d;

  assign fetch_pri = bus.if_req && (lose_cnt_q == LIMIT);

  // Read arbitration: data first unless fetch has starved; a RAW-blocked
  // winner hands the slot to the other requester. Nothing is granted while
  // reset is asserted.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (resetb) begin
      if (fetch_pri) begin
        if (if_ok)     grant_if = 1'b1;
        else if (d_ok) grant_d  = 1'b1;
      end else begin
        if (d_ok)       grant_d  = 1'b1;
        else if (if_ok) grant_if = 1'b1;
      end
    end
  end

  // Next owner and starvation counter.
  always_comb begin
    owner_d    = OWN_NONE;
    lose_cnt_d = lose_cnt_q;
    if (grant_if)     owner_d = OWN_IF;
    else if (grant_d) owner_d = OWN_D;

    if (grant_if) begin
      lose_cnt_d = 4'd0;
    end else if (bus.if_req && (lose_cnt_q < LIMIT)) begin
      lose_cnt_d = lose_cnt_q + 4'd1;
    end
  end

  // Owner and starvation counter registers; reset drops any in-flight read.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      owner_q    <= OWN_NONE;
      lose_cnt_q <= 4'd0;
    end else begin
      owner_q    <= owner_d;
      lose_cnt_q <= lose_cnt_d;
    end
  end

  assign bus.if_gnt     = grant_if;
  assign bus.d_gnt      = grant_d;
  assign bus.mem_rready = grant_if || grant_d;
  assign bus.mem_raddr  = grant_if ? if_word :
                          grant_d  ? d_word  : '0;

  assign bus.if_rvalid  = (owner_q == OWN_IF);
  assign bus.d_rvalid   = (owner_q == OWN_D);
  assign bus.if_rdata   = bus.mem_rdata;
  assign bus.d_rdata    = bus.mem_rdata;

  // Write port is a pass-through, forced quiet while reset is asserted.
  assign bus.mem_wready = resetb && mem_w;
  assign bus.mem_waddr  = resetb ? w_word      : '0;
  assign bus.mem_wdata  = resetb ? bus.d_wdata : '0;
  assign bus.mem_wstrb  = resetb ? bus.d_wstrb : '0;

`ifdef MMIO_DECODE_EN
  logic       putc_valid_q;
  logic [7:0] putc_char_q;
  logic       exit_q;

  // PUTC is a one-cycle registered pulse; EXIT is sticky until reset.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      putc_valid_q <= 1'b0;
      putc_char_q  <= 8'h00;
      exit_q       <= 1'b0;
    end else begin
      putc_valid_q <= mmio_putc;
      if (mmio_putc) putc_char_q <= bus.d_wdata[7:0];
      if (mmio_exit) exit_q      <= 1'b1;
    end
  end

  assign bus.putc_valid = putc_valid_q;
  assign bus.putc_char  = putc_char_q;
  assign bus.exit_req   = exit_q;
`else
  assign bus.putc_valid = 1'b0;
  assign bus.putc_char  = 8'h00;
  assign bus.exit_req   = 1'b0;
`endif

  // Byte-offset bits are meaningless on a word-wide memory.
  logic unused_bits;
  assign unused_bits = ^{bus.if_addr[1:0], bus.d_raddr[1:0], bus.d_waddr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a word memory behind the read/write ports.
// Memory word i starts as 32'hA000_0000 | i.
module tb_mem_arbiter;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  // Memory model: 1-cycle read latency, byte-strobed writes.
  logic [31:0] mem [1024];
  bit          mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
      mem_init = 1'b1;
    end
    if (bus.mem_rready) bus.mem_rdata <= mem[bus.mem_raddr[9:0]];
    if (bus.mem_wready) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_wstrb[b]) mem[bus.mem_waddr[9:0]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.if_req  = 1'b0;
    bus.if_addr = 32'h0;
    bus.d_rreq  = 1'b0;
    bus.d_raddr = 32'h0;
    bus.d_wreq  = 1'b0;
    bus.d_waddr = 32'h0;
    bus.d_wdata = 32'h0;
    bus.d_wstrb = 4'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.d_wreq  = 1'b1;
    bus.d_waddr = a;
    bus.d_wdata = d;
    bus.d_wstrb = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    cyc(); cyc();

    // ---- reset state, with requests pushing on every port ----
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.d_rreq = 1'b1; bus.d_raddr = 32'h200;
    wr(32'h200, 32'hDEAD_BEEF, 4'hF);
    smp();
    chk("rst_if_gnt",     bus.if_gnt,     0);
    chk("rst_d_gnt",      bus.d_gnt,      0);
    chk("rst_if_rvalid",  bus.if_rvalid,  0);
    chk("rst_d_rvalid",   bus.d_rvalid,   0);
    chk("rst_mem_rready", bus.mem_rready, 0);
    chk("rst_mem_raddr",  bus.mem_raddr,  0);
    chk("rst_mem_wready", bus.mem_wready, 0);
    chk("rst_mem_waddr",  bus.mem_waddr,  0);
    chk("rst_mem_wdata",  bus.mem_wdata,  0);
    chk("rst_mem_wstrb",  bus.mem_wstrb,  0);
    chk("rst_putc_valid", bus.putc_valid, 0);
    chk("rst_putc_char",  bus.putc_char,  0);
    chk("rst_exit_req",   bus.exit_req,   0);
    cyc();
    idle();
    resetb = 1'b1;
    cyc();

    // ---- single fetch ----
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    smp();
    chk("f1_if_gnt",     bus.if_gnt,     1);
    chk("f1_d_gnt",      bus.d_gnt,      0);
    chk("f1_mem_rready", bus.mem_rready, 1);
    chk("f1_mem_raddr",  bus.mem_raddr,  32'h40);
    cyc();
    idle();
    smp();
    chk("f1_if_rvalid", bus.if_rvalid, 1);
    chk("f1_d_rvalid",  bus.d_rvalid,  0);
    chk("f1_if_rdata",  bus.if_rdata,  32'hA000_0040);
    chk("f1_if_gnt_off", bus.if_gnt,   0);
    cyc();
    smp();
    chk("f1_if_rvalid_off", bus.if_rvalid, 0);
    cyc();

    // ---- continuous contention: D,D,D,D,IF repeating ----
    bus.d_rreq = 1'b1; bus.d_raddr = 32'h200;
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    for (int k = 0; k < 10; k++) begin
      smp();
      chk($sformatf("st_d_gnt%0d", k),  bus.d_gnt,  32'(k % 5 != 4));
      chk($sformatf("st_if_gnt%0d", k), bus.if_gnt, 32'(k % 5 == 4));
      if (k > 0) begin
        chk($sformatf("st_d_rvalid%0d", k),  bus.d_rvalid,  32'((k - 1) % 5 != 4));
        chk($sformatf("st_if_rvalid%0d", k), bus.if_rvalid, 32'((k - 1) % 5 == 4));
        chk($sformatf("st_rdata%0d", k), bus.d_rdata,
            ((k - 1) % 5 == 4) ? 32'hA000_0041 : 32'hA000_0080);
      end
      cyc();
    end
    idle();
    smp();
    chk("st_last_if_rvalid", bus.if_rvalid, 1);
    chk("st_last_if_rdata",  bus.if_rdata,  32'hA000_0041);
    cyc();

    // ---- RAW on the data port ----
    wr(32'h200, 32'h1234_5678, 4'hF);
    bus.d_rreq = 1'b1; bus.d_raddr = 32'h200;
    smp();
    chk("raw_d_gnt_blk",  bus.d_gnt,      0);
    chk("raw_rready_blk", bus.mem_rready, 0);
    chk("raw_wready",     bus.mem_wready, 1);
    chk("raw_waddr",      bus.mem_waddr,  32'h80);
    chk("raw_wdata",      bus.mem_wdata,  32'h1234_5678);
    chk("raw_wstrb",      bus.mem_wstrb,  4'hF);
    cyc();
    bus.d_wreq = 1'b0;
    smp();
    chk("raw_d_gnt", bus.d_gnt,     1);
    chk("raw_raddr", bus.mem_raddr, 32'h80);
    cyc();
    idle();
    smp();
    chk("raw_d_rvalid", bus.d_rvalid, 1);
    chk("raw_d_rdata",  bus.d_rdata,  32'h1234_5678);
    cyc();

    // ---- independent write and fetch in the same cycle ----
    wr(32'h300, 32'hCAFE_F00D, 4'b0011);
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    smp();
    chk("wf_if_gnt", bus.if_gnt,     1);
    chk("wf_wready", bus.mem_wready, 1);
    chk("wf_raddr",  bus.mem_raddr,  32'h41);
    chk("wf_waddr",  bus.mem_waddr,  32'hC0);
    chk("wf_wstrb",  bus.mem_wstrb,  4'b0011);
    cyc();
    idle();
    bus.d_rreq = 1'b1; bus.d_raddr = 32'h300;
    smp();
    chk("wf_if_rvalid", bus.if_rvalid, 1);
    chk("wf_if_rdata",  bus.if_rdata,  32'hA000_0041);
    chk("wf_d_gnt",     bus.d_gnt,     1);
    cyc();
    idle();
    smp();
    chk("wf_part_rvalid", bus.d_rvalid, 1);
    chk("wf_part_rdata",  bus.d_rdata,  32'hA000_F00D);
    cyc();

    // ---- data blocked by RAW hands the slot to fetch ----
    wr(32'h200, 32'h55AA_55AA, 4'hF);
    bus.d_rreq = 1'b1; bus.d_raddr = 32'h200;
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    smp();
    chk("alt_d_gnt",  bus.d_gnt,     0);
    chk("alt_if_gnt", bus.if_gnt,    1);
    chk("alt_raddr",  bus.mem_raddr, 32'h41);
    cyc();
    bus.d_wreq = 1'b0;
    bus.if_req = 1'b0;
    smp();
    chk("alt_if_rvalid", bus.if_rvalid, 1);
    chk("alt_d_gnt2",    bus.d_gnt,     1);
    cyc();
    idle();
    smp();
    chk("alt_d_rvalid", bus.d_rvalid, 1);
    chk("alt_d_rdata",  bus.d_rdata,  32'h55AA_55AA);
    cyc();

    // ---- RAW on the fetch port ----
    wr(32'h104, 32'h0BAD_F00D, 4'hF);
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    smp();
    chk("fraw_if_gnt_blk", bus.if_gnt,     0);
    chk("fraw_rready_blk", bus.mem_rready, 0);
    cyc();
    bus.d_wreq = 1'b0;
    smp();
    chk("fraw_if_gnt", bus.if_gnt, 1);
    cyc();
    idle();
    smp();
    chk("fraw_if_rvalid", bus.if_rvalid, 1);
    chk("fraw_if_rdata",  bus.if_rdata,  32'h0BAD_F00D);
    cyc();

    // ---- MMIO addresses ----
`ifdef MMIO_DECODE_EN
    wr(MEM_PUTC, 32'h0000_0041, 4'h1);
    bus.d_rreq = 1'b1; bus.d_raddr = MEM_PUTC;
    smp();
    chk("putc_wready",     bus.mem_wready, 0);
    chk("putc_no_raw",     bus.d_gnt,      1);
    chk("putc_valid_pre",  bus.putc_valid, 0);
    cyc();
    idle();
    smp();
    chk("putc_valid", bus.putc_valid, 1);
    chk("putc_char",  bus.putc_char,  8'h41);
    cyc();
    smp();
    chk("putc_valid_off", bus.putc_valid, 0);
    wr(MEM_EXIT, 32'h0000_0000, 4'hF);
    smp();
    chk("exit_wready", bus.mem_wready, 0);
    cyc();
    idle();
    smp();
    chk("exit_req_set", bus.exit_req, 1);
    cyc(); cyc();
    smp();
    chk("exit_req_hold", bus.exit_req, 1);
    cyc();
`else
    wr(MEM_PUTC, 32'h0000_0041, 4'h1);
    smp();
    chk("mmio_off_wready", bus.mem_wready, 1);
    chk("mmio_off_waddr",  bus.mem_waddr,  32'h2000_0007);
    cyc();
    idle();
    smp();
    chk("mmio_off_putc", bus.putc_valid, 0);
    chk("mmio_off_exit", bus.exit_req,   0);
    cyc();
`endif

    // ---- reset with a data read in flight and lose_cnt at 2 ----
    bus.d_rreq = 1'b1; bus.d_raddr = 32'h200;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    for (int k = 0; k < 2; k++) begin
      smp();
      chk($sformatf("mr_d_gnt%0d", k), bus.d_gnt, 1);
      cyc();
    end
    resetb = 1'b0;
    smp();
    chk("mr_d_rvalid",  bus.d_rvalid,    0);
    chk("mr_d_gnt",     bus.d_gnt,       0);
    chk("mr_if_gnt",    bus.if_gnt,      0);
    chk("mr_rready",    bus.mem_rready,  0);
    cyc();
    idle();
    cyc();
    resetb = 1'b1;
    smp();
    chk("mr_rel_d_rvalid",  bus.d_rvalid,  0);
    chk("mr_rel_if_rvalid", bus.if_rvalid, 0);
    chk("mr_rel_exit",      bus.exit_req,  0);
    cyc();
    bus.d_rreq = 1'b1; bus.d_raddr = 32'h200;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk($sformatf("mr_post_d_gnt%0d", k),  bus.d_gnt,  32'(k != 4));
      chk($sformatf("mr_post_if_gnt%0d", k), bus.if_gnt, 32'(k == 4));
      cyc();
    end
    idle();
    smp();
    chk("mr_post_if_rvalid", bus.if_rvalid, 1);
    chk("mr_post_if_rdata",  bus.if_rdata,  32'hA000_0040);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one memmodel-style memory between the IF_ID instruction-fetch port and the execute-stage data port, replacing the separate imem/dmem instances with a unified memory. Data writes use the memory's write port directly. Instruction fetches and data reads compete for the single read port under a data-priority policy with a starvation guard. The block tracks the single outstanding read and routes the returned word to its owner. Optionally, it intercepts the PUTC/EXIT MMIO writes.

## Interface
- `STARVE_LIMIT`, default 4: consecutive lost read arbitrations after which fetch wins; legal range 1..15.
- `clk` in 1: clock.
- `resetb` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch read request; held until granted.
- `if_addr` in 32: fetch byte address.
- `if_gnt` out 1: fetch request accepted this cycle.
- `if_rvalid` out 1: fetch data valid.
- `if_rdata` out 32: fetch data.
- `d_rreq` in 1: data read request; held until granted.
- `d_raddr` in 32: data read byte address.
- `d_gnt` out 1: data read accepted this cycle.
- `d_rvalid` out 1: data read data valid.
- `d_rdata` out 32: data read data.
- `d_wreq` in 1: data write request.
- `d_waddr` in 32: data write byte address.
- `d_wdata` in 32: data write data.
- `d_wstrb` in 4: data write byte strobes.
- `mem_rready` out 1: memory read strobe.
- `mem_raddr` out 30: memory read word address.
- `mem_rdata` in 32: memory read data, valid the cycle after `mem_rready`.
- `mem_wready` out 1: memory write strobe.
- `mem_waddr` out 30: memory write word address.
- `mem_wdata` out 32: memory write data.
- `mem_wstrb` out 4: memory write strobes.
- `putc_valid` out 1: character-output write seen (`MMIO_DECODE_EN` only).
- `putc_char` out 8: the character (`MMIO_DECODE_EN` only).
- `exit_req` out 1: program exit write seen (`MMIO_DECODE_EN` only).

## Operation
- Writes are never stalled. `d_wreq` drives `mem_wready` combinationally. `mem_waddr` = `d_waddr[31:2]`; data and strobes pass through.
- Read arbitration is combinational each cycle. Data reads win unless `lose_cnt == STARVE_LIMIT` and `if_req` is high; in that case fetch wins.
- `lose_cnt` is 4 bits.
  - Increments when `if_req` is high and fetch is not granted.
  - Clears on `if_gnt`.
  - Saturates at `STARVE_LIMIT`.
- RAW hazard: a read is not granted in a cycle where `d_wreq` targets the same word address. This applies to either requester.
  - If the winner is blocked this way, the other requester is considered. A deferred fetch still counts as a loss.
- On grant:
  - `mem_rready` = 1, and `mem_raddr` takes the winner's address `[31:2]`.
  - The owner register loads IF or D; otherwise it loads NONE.
- The cycle after a grant, `mem_rdata` routes to the owner. `if_rvalid` = (owner == IF); `d_rvalid` = (owner == D).
- `if_rdata` and `d_rdata` both mirror `mem_rdata`. Consumers qualify them with their rvalid.
- Back-to-back reads: a new grant may occur in the same cycle the previous data returns. This gives full throughput of one read per cycle.
- Reset assertion, including mid-transaction:
  - owner → NONE, `lose_cnt` → 0.
  - All grants, strobes and rvalids → 0 immediately.
  - The in-flight read is dropped, and no rvalid follows reset release.

## Timing
- Reset values: `if_gnt`, `d_gnt`, `if_rvalid`, `d_rvalid`, `mem_rready`, `mem_wready`, `putc_valid`, `exit_req` = 0.
- Reset values: `mem_raddr`, `mem_waddr`, `mem_wdata`, `mem_wstrb`, `putc_char` = 0.
- Read latency is 1 cycle: grant in cycle N, rvalid and data in cycle N+1.
- Writes take effect at the clk edge ending the request cycle.
- A requester must hold its request and address stable until grant. It may drop the request the cycle after grant.
- Worst-case fetch wait under a continuous data-read stream is `STARVE_LIMIT` cycles, plus 1 cycle per RAW deferral.

## Configuration
- `MMIO_DECODE_EN` defined:
  - A `d_wreq` to `32'h8000001c` suppresses `mem_wready` and pulses `putc_valid` for one cycle, registered, with `putc_char` = `d_wdata[7:0]`.
  - A `d_wreq` to `32'h8000002c` suppresses `mem_wready` and sets `exit_req`, which stays high until reset.
  - RAW checks ignore these addresses.
- `MMIO_DECODE_EN` undefined: all writes go to memory; `putc_valid`, `putc_char` and `exit_req` are tied to 0.

## Structure
- Shared package `mem_pkg`:
  - owner enum NONE/IF/D.
  - `MEM_PUTC` and `MEM_EXIT` address constants.
  - word-address width (30).
- Single module with no sub-module. The priority/starvation logic is small enough to stay inline.

## Test plan
- `if_req` alone, `if_addr`=0x100 → `if_gnt` in cycle 0, `mem_raddr`=0x40; `if_rvalid` in cycle 1 with memory word 0x40.
- `d_rreq` and `if_req` held continuously, `STARVE_LIMIT`=4 → data granted 4 cycles, fetch granted in the 5th, pattern repeats; rvalids return to the correct owner.
- `d_wreq` to 0x200 plus `d_rreq` to 0x200 in the same cycle → no `d_gnt` that cycle; grant the next cycle; returned data equals the written value.
- `d_wreq` to 0x300 plus `if_req` to 0x104 in the same cycle → both serviced in the same cycle.
- Fetch grant, then `resetb` low on the following edge → no `if_rvalid` after release; `lose_cnt` and all outputs at 0.
- With `MMIO_DECODE_EN`, write 0x41 to 0x8000001c → `putc_valid` one cycle with `putc_char`=0x41, `mem_wready` stays 0; then a write to 0x8000002c → `exit_req` = 1 and stays high.
